// File: rtl/cc_stim_master.sv
// Initiator for the CC engine: serializes one command (mode + four points) as a
// 4-beat in_valid burst, then collects the response burst into counts and sums.
module cc_stim_master #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [31:0]      cmd_x,
    input  logic [31:0]      cmd_y,
    output logic             in_valid,
    output logic [1:0]       mode,
    output logic [7:0]       xi,
    output logic [7:0]       yi,
    input  logic             out_valid,
    input  logic [7:0]       xo,
    input  logic [7:0]       yo,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_count,
    output logic [CNT_W-1:0] res_xsum,
    output logic [CNT_W-1:0] res_ysum,
    output logic [15:0]      res_first,
    output logic             res_timeout,
    output logic             res_err,
    output logic [2:0]       dbg_state
);

    // Command side: a transfer happens on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on the state register. The CC side has no back-pressure:
    // in_valid and out_valid are unconditional one-cycle beats.
    typedef enum logic [2:0] {IDLE, SEND, WAIT, COLLECT, DONE} state_t;

    state_t           state, state_n;
    logic [1:0]       beat, beat_n;
    logic [31:0]      x_lat, x_lat_n, y_lat, y_lat_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic [CNT_W-1:0] acc_count, acc_count_n, acc_xsum, acc_xsum_n, acc_ysum, acc_ysum_n;
    logic [15:0]      acc_first, acc_first_n;
    logic             acc_timeout, acc_timeout_n, acc_err, acc_err_n;
    logic             in_valid_n;
    logic [1:0]       mode_n;
    logic [7:0]       xi_n, yi_n;
    logic             load_res;

    assign cmd_ready = (state == IDLE);
    assign dbg_state = state;

    always_comb begin
        state_n       = state;
        beat_n        = beat;
        x_lat_n       = x_lat;
        y_lat_n       = y_lat;
        wait_cnt_n    = wait_cnt;
        acc_count_n   = acc_count;
        acc_xsum_n    = acc_xsum;
        acc_ysum_n    = acc_ysum;
        acc_first_n   = acc_first;
        acc_timeout_n = acc_timeout;
        acc_err_n     = acc_err;
        in_valid_n    = 1'b0;
        mode_n        = 2'd0;
        xi_n          = 8'd0;
        yi_n          = 8'd0;
        load_res      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_n       = SEND;
                    beat_n        = 2'd0;
                    x_lat_n       = cmd_x;
                    y_lat_n       = cmd_y;
                    acc_count_n   = '0;
                    acc_xsum_n    = '0;
                    acc_ysum_n    = '0;
                    acc_first_n   = '0;
                    acc_timeout_n = 1'b0;
                    acc_err_n     = 1'b0;
                    in_valid_n    = 1'b1;
                    mode_n        = cmd_mode;
                    xi_n          = cmd_x[7:0];
                    yi_n          = cmd_y[7:0];
                end
            end
            SEND: begin
                if (out_valid) acc_err_n = 1'b1;
                if (beat == 2'd3) begin
                    state_n    = WAIT;
                    wait_cnt_n = '0;
                end else begin
                    beat_n     = beat + 2'd1;
                    in_valid_n = 1'b1;
                    mode_n     = mode;
                    xi_n       = x_lat[{beat_n, 3'b000} +: 8];
                    yi_n       = y_lat[{beat_n, 3'b000} +: 8];
                end
            end
            WAIT: begin
                // A beat arriving on the last allowed cycle still wins over the timeout.
                if (out_valid) begin
                    state_n     = COLLECT;
                    acc_count_n = CNT_W'(1);
                    acc_xsum_n  = {{(CNT_W-8){1'b0}}, xo};
                    acc_ysum_n  = {{(CNT_W-8){1'b0}}, yo};
                    acc_first_n = {xo, yo};
                end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                    state_n       = DONE;
                    acc_timeout_n = 1'b1;
                    load_res      = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                end
            end
            COLLECT: begin
                if (out_valid) begin
                    if (acc_count != {CNT_W{1'b1}}) acc_count_n = acc_count + CNT_W'(1);
                    acc_xsum_n = acc_xsum + {{(CNT_W-8){1'b0}}, xo};
                    acc_ysum_n = acc_ysum + {{(CNT_W-8){1'b0}}, yo};
                end else begin
                    state_n  = DONE;
                    load_res = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat        <= 2'd0;
            x_lat       <= '0;
            y_lat       <= '0;
            wait_cnt    <= '0;
            acc_count   <= '0;
            acc_xsum    <= '0;
            acc_ysum    <= '0;
            acc_first   <= '0;
            acc_timeout <= 1'b0;
            acc_err     <= 1'b0;
            in_valid    <= 1'b0;
            mode        <= 2'd0;
            xi          <= 8'd0;
            yi          <= 8'd0;
            res_valid   <= 1'b0;
            res_count   <= '0;
            res_xsum    <= '0;
            res_ysum    <= '0;
            res_first   <= '0;
            res_timeout <= 1'b0;
            res_err     <= 1'b0;
        end else begin
            state       <= state_n;
            beat        <= beat_n;
            x_lat       <= x_lat_n;
            y_lat       <= y_lat_n;
            wait_cnt    <= wait_cnt_n;
            acc_count   <= acc_count_n;
            acc_xsum    <= acc_xsum_n;
            acc_ysum    <= acc_ysum_n;
            acc_first   <= acc_first_n;
            acc_timeout <= acc_timeout_n;
            acc_err     <= acc_err_n;
            in_valid    <= in_valid_n;
            mode        <= mode_n;
            xi          <= xi_n;
            yi          <= yi_n;
            res_valid   <= load_res;
            // Results are latched on entry to DONE and held until the next DONE.
            if (load_res) begin
                res_count   <= acc_count_n;
                res_xsum    <= acc_xsum_n;
                res_ysum    <= acc_ysum_n;
                res_first   <= acc_first_n;
                res_timeout <= acc_timeout_n;
                res_err     <= acc_err_n;
            end
        end
    end

endmodule

// File: tb/tb_cc_stim_master.sv
// Bench for cc_stim_master: drives commands, acts as the CC responder, and scores
// every in_valid beat and every res_valid pulse against queued expectations.
module tb_cc_stim_master;

    localparam int TIMEOUT = 1023;
    localparam int CNT_W   = 16;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [31:0]      cmd_x;
    logic [31:0]      cmd_y;
    logic             in_valid;
    logic [1:0]       mode;
    logic [7:0]       xi;
    logic [7:0]       yi;
    logic             out_valid;
    logic [7:0]       xo;
    logic [7:0]       yo;
    logic             res_valid;
    logic [CNT_W-1:0] res_count;
    logic [CNT_W-1:0] res_xsum;
    logic [CNT_W-1:0] res_ysum;
    logic [15:0]      res_first;
    logic             res_timeout;
    logic             res_err;
    logic [2:0]       dbg_state;

    cc_stim_master #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_x(cmd_x), .cmd_y(cmd_y),
        .in_valid(in_valid), .mode(mode), .xi(xi), .yi(yi),
        .out_valid(out_valid), .xo(xo), .yo(yo),
        .res_valid(res_valid), .res_count(res_count), .res_xsum(res_xsum),
        .res_ysum(res_ysum), .res_first(res_first), .res_timeout(res_timeout),
        .res_err(res_err), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state: beats are {mode,xi,yi}; results are {count,xsum,ysum,first,timeout,err}
    int          n_checks = 0;
    int          n_bad    = 0;
    logic [17:0] beat_q[$];
    logic [65:0] res_q[$];
    int          res_seen = 0;
    logic [7:0]  resp_x[8];
    logic [7:0]  resp_y[8];
    logic [17:0] mon_b;
    logic [65:0] mon_r;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid) begin
                if (beat_q.size() == 0) begin
                    check("beat_extra", 64'(in_valid), 64'd0);
                end else begin
                    mon_b = beat_q.pop_front();
                    check("beat", 64'({mode, xi, yi}), 64'(mon_b));
                end
            end else begin
                check("bus_idle", 64'({mode, xi, yi}), 64'd0);
            end
            if (res_valid) begin
                res_seen++;
                if (res_q.size() == 0) begin
                    check("res_extra", 64'(res_valid), 64'd0);
                end else begin
                    mon_r = res_q.pop_front();
                    check("res_count", 64'(res_count), 64'(mon_r[65:50]));
                    check("res_xsum", 64'(res_xsum), 64'(mon_r[49:34]));
                    check("res_ysum", 64'(res_ysum), 64'(mon_r[33:18]));
                    check("res_first", 64'(res_first), 64'(mon_r[17:2]));
                    check("res_timeout", 64'(res_timeout), 64'(mon_r[1]));
                    check("res_err", 64'(res_err), 64'(mon_r[0]));
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    // Returns at the mid-cycle point of beat 0.
    task automatic send_cmd(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y);
        int guard = 0;
        for (int k = 0; k < 4; k++) beat_q.push_back({m, x[8*k +: 8], y[8*k +: 8]});
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_x     = x;
        cmd_y     = y;
        while (!cmd_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_x     = 32'd0;
        cmd_y     = 32'd0;
        check("rdy_busy", 64'(cmd_ready), 64'd0);
    endtask

    // Full transaction: n response beats from resp_x/resp_y, first one dly cycles
    // after the first WAIT cycle; optional stray out_valid during beat 2.
    task automatic run_txn(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                           input int n, input int dly, input bit err_pulse, output int lat);
        logic [15:0] c, sx, sy, f;
        int b3;
        int guard;
        c = '0; sx = '0; sy = '0; f = '0;
        for (int i = 0; i < n; i++) begin
            c  = c + 16'd1;
            sx = sx + 16'(resp_x[i]);
            sy = sy + 16'(resp_y[i]);
        end
        if (n > 0) f = {resp_x[0], resp_y[0]};
        res_q.push_back({c, sx, sy, f, (n == 0), err_pulse});
        lat = -1;
        send_cmd(m, x, y);
        check("iv_beat0", 64'(in_valid), 64'd1);
        tick();
        tick();
        if (err_pulse) begin
            out_valid = 1'b1;
            xo = 8'haa;
            yo = 8'h55;
        end
        tick();
        out_valid = 1'b0;
        xo = 8'd0;
        yo = 8'd0;
        check("iv_beat3", 64'(in_valid), 64'd1);
        b3 = cyc;
        tick();
        check("iv_end", 64'(in_valid), 64'd0);
        if (n > 0) begin
            for (int i = 0; i < dly; i++) tick();
            for (int i = 0; i < n; i++) begin
                out_valid = 1'b1;
                xo = resp_x[i];
                yo = resp_y[i];
                tick();
            end
            out_valid = 1'b0;
            xo = 8'd0;
            yo = 8'd0;
        end
        guard = 0;
        while (!res_valid && guard < TIMEOUT + 100) begin
            tick();
            guard++;
        end
        if (res_valid) begin
            lat = cyc - b3;
            check("rdy_in_done", 64'(cmd_ready), 64'd0);
            tick();
            check("rdy_rise", 64'(cmd_ready), 64'd1);
            check("res_pulse", 64'(res_valid), 64'd0);
        end else begin
            check("wait_res", 64'(res_valid), 64'd1);
        end
    endtask

    int          lat;
    int          seen0;
    int          bursts, dones, end1, start2, guard;
    bit          iv_prev, after_done;
    logic [31:0] xa, ya, xb, yb;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_x     = 32'd0;
        cmd_y     = 32'd0;
        out_valid = 1'b0;
        xo        = 8'd0;
        yo        = 8'd0;
        repeat (3) tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_cc_bus", 64'({in_valid, mode, xi, yi}), 64'd0);
        check("rst_res_valid", 64'({res_valid, res_timeout, res_err}), 64'd0);
        check("rst_res_sums", 64'({res_count, res_xsum, res_ysum, res_first}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic send with a 3-beat response starting 2 cycles after beat 3
        resp_x[0] = 8'd1; resp_y[0] = 8'd2;
        resp_x[1] = 8'd3; resp_y[1] = 8'd4;
        resp_x[2] = 8'd5; resp_y[2] = 8'd6;
        run_txn(2'd2, {8'd4, 8'd4, 8'd0, 8'd0}, {8'd4, 8'd0, 8'd4, 8'd0}, 3, 1, 1'b0, lat);

        // Stray out_valid during SEND, then a single beat (0,2)
        resp_x[0] = 8'd0; resp_y[0] = 8'd2;
        run_txn(2'd1, 32'h1122_3344, 32'h5566_7788, 1, 0, 1'b1, lat);

        // First beat exactly when the wait counter equals TIMEOUT
        resp_x[0] = 8'd7; resp_y[0] = 8'd9;
        run_txn(2'd1, 32'h0102_0304, 32'h0506_0708, 1, TIMEOUT, 1'b0, lat);

        // Illegal mode, silent responder: counter runs 0..TIMEOUT, then DONE
        run_txn(2'd3, 32'hdead_beef, 32'hcafe_f00d, 0, 0, 1'b0, lat);
        check("timeout_lat", 64'(lat - 1), 64'(TIMEOUT + 1));

        // Randomized transactions
        for (int it = 0; it < 6; it++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                resp_x[i] = 8'($urandom_range(0, 255));
                resp_y[i] = 8'($urandom_range(0, 255));
            end
            run_txn(2'($urandom_range(0, 2)), $urandom, $urandom, n,
                    int'($urandom_range(0, 6)), 1'b0, lat);
        end

        // Back-to-back with cmd_valid held high; responder answers on the first WAIT cycle
        xa = $urandom; ya = $urandom; xb = $urandom; yb = $urandom;
        for (int k = 0; k < 4; k++) beat_q.push_back({2'd2, xa[8*k +: 8], ya[8*k +: 8]});
        res_q.push_back({16'd1, 16'd3, 16'd3, 16'h0303, 1'b0, 1'b0});
        cmd_valid = 1'b1;
        cmd_mode  = 2'd2;
        cmd_x     = xa;
        cmd_y     = ya;
        bursts = 0; dones = 0; end1 = 0; start2 = 0; guard = 0;
        iv_prev = 1'b0; after_done = 1'b0;
        while ((dones < 2 || after_done) && guard < 200) begin
            tick();
            guard++;
            if (in_valid && !iv_prev) begin
                bursts++;
                if (bursts == 1) begin
                    for (int k = 0; k < 4; k++) beat_q.push_back({2'd1, xb[8*k +: 8], yb[8*k +: 8]});
                    res_q.push_back({16'd1, 16'd3, 16'd3, 16'h0303, 1'b0, 1'b0});
                    cmd_mode = 2'd1;
                    cmd_x    = xb;
                    cmd_y    = yb;
                end else begin
                    start2 = cyc;
                end
            end
            if (!in_valid && iv_prev) begin
                out_valid = 1'b1;
                xo = 8'd3;
                yo = 8'd3;
                if (bursts == 1) end1 = cyc;
            end else begin
                out_valid = 1'b0;
                xo = 8'd0;
                yo = 8'd0;
            end
            if (in_valid) check("b2b_rdy_busy", 64'(cmd_ready), 64'd0);
            if (after_done) begin
                check("b2b_rdy_rise", 64'(cmd_ready), 64'd1);
                after_done = 1'b0;
            end
            if (res_valid) begin
                check("b2b_rdy_done", 64'(cmd_ready), 64'd0);
                dones++;
                after_done = 1'b1;
                if (dones == 2) cmd_valid = 1'b0;
            end
            iv_prev = in_valid;
        end
        cmd_valid = 1'b0;
        out_valid = 1'b0;
        check("b2b_dones", 64'(dones), 64'd2);
        check("b2b_gap", 64'(start2 - end1), 64'd4);

        // Reset asserted during beat 1 drops the transaction
        send_cmd(2'd2, 32'h1234_5678, 32'h9abc_def0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_iv", 64'(in_valid), 64'd0);
        check("rst_mid_bus", 64'({mode, xi, yi}), 64'd0);
        check("rst_mid_rdy", 64'(cmd_ready), 64'd1);
        beat_q.delete();
        seen0 = res_seen;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_rel_rdy", 64'(cmd_ready), 64'd1);
        repeat (TIMEOUT + 20) tick();
        check("rst_lost_res", 64'(res_seen - seen0), 64'd0);
        check("rst_idle_rdy", 64'(cmd_ready), 64'd1);

        // Final report
        check("beat_q_left", 64'(beat_q.size()), 64'd0);
        check("res_q_left", 64'(res_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
